// File: rtl/mcdt_arb_n_if.sv
// Channel-side and output-side signal bundle for the NCH-channel merger.
// The DUT takes the slave modport; the producer/consumer side takes master.
interface mcdt_arb_n_if #(
  parameter int NCH   = 3,
  parameter int DW    = 32,
  parameter int DEPTH = 32
);
  localparam int IDW = ($clog2(NCH) < 1) ? 1 : $clog2(NCH);
  localparam int MW  = $clog2(DEPTH) + 1;

  logic [NCH*DW-1:0] ch_data_i;
  logic [NCH-1:0]    ch_valid_i;
  logic [NCH-1:0]    ch_ready_o;
  logic [NCH*MW-1:0] ch_margin_o;
  logic [NCH-1:0]    ch_en_i;
  logic              arb_mode_i;
  logic [DW-1:0]     out_data_o;
  logic              out_val_o;
  logic [IDW-1:0]    out_id_o;
  logic              out_ready_i;

  modport slave (
    input  ch_data_i, ch_valid_i, ch_en_i, arb_mode_i, out_ready_i,
    output ch_ready_o, ch_margin_o, out_data_o, out_val_o, out_id_o
  );

  modport master (
    output ch_data_i, ch_valid_i, ch_en_i, arb_mode_i, out_ready_i,
    input  ch_ready_o, ch_margin_o, out_data_o, out_val_o, out_id_o
  );
endinterface

// File: rtl/mcdt_arb_n.sv
// NCH per-channel FIFOs merged onto one ID-tagged output stream with
// fixed-priority or round-robin arbitration and downstream backpressure.
module mcdt_arb_n #(
  parameter int NCH   = 3,
  parameter int DW    = 32,
  parameter int DEPTH = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  mcdt_arb_n_if.slave  bus
);
  localparam int IDW = ($clog2(NCH) < 1) ? 1 : $clog2(NCH);
  localparam int MW  = $clog2(DEPTH) + 1;
  localparam int AW  = $clog2(DEPTH);

  logic [NCH-1:0]    w_ready;
  logic [NCH-1:0]    w_push;
  logic [NCH-1:0]    w_pop;
  logic [NCH-1:0]    w_cand;
  logic [NCH*DW-1:0] w_head;
  logic              w_load;
  logic              w_gnt_vld;
  logic [IDW-1:0]    w_gnt_idx;
  logic [DW-1:0]     w_gnt_data;

  logic [DW-1:0]     r_out_data;
  logic [IDW-1:0]    r_out_id;
  logic              r_out_val;
  logic [IDW-1:0]    r_rr_ptr;

  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] ptr, input int k);
    return IDW'((int'(ptr) + k) % NCH);
  endfunction

  assign w_load = !r_out_val | bus.out_ready_i;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [MW-1:0] r_cnt;

    // Ready looks only at the registered count, so a pop never frees a slot in the same cycle.
    assign w_ready[g] = bus.ch_en_i[g] & (r_cnt < MW'(DEPTH));
    assign w_push[g]  = bus.ch_valid_i[g] & w_ready[g];
    assign w_pop[g]   = w_load & w_gnt_vld & (w_gnt_idx == IDW'(g));
    assign w_cand[g]  = (r_cnt != '0);
    assign w_head[g*DW +: DW]      = r_mem[r_rptr];
    assign bus.ch_margin_o[g*MW +: MW] = MW'(DEPTH) - r_cnt;
    assign bus.ch_ready_o[g]       = w_ready[g];

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_cnt  <= '0;
      end else begin
        if (w_push[g]) r_wptr <= r_wptr + 1'b1;
        if (w_pop[g])  r_rptr <= r_rptr + 1'b1;
        case ({w_push[g], w_pop[g]})
          2'b10:   r_cnt <= r_cnt + 1'b1;
          2'b01:   r_cnt <= r_cnt - 1'b1;
          default: r_cnt <= r_cnt;
        endcase
      end
    end

    always_ff @(posedge clk_i) begin
      if (w_push[g]) r_mem[r_wptr] <= bus.ch_data_i[g*DW +: DW];
    end
  end

  // Descending scans so the last hit, i.e. the highest-priority candidate, wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    if (!bus.arb_mode_i) begin
      for (int i = NCH - 1; i >= 0; i--) begin
        if (w_cand[i]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = IDW'(i);
        end
      end
    end else begin
      for (int k = NCH; k >= 1; k--) begin
        if (w_cand[rr_idx(r_rr_ptr, k)]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = rr_idx(r_rr_ptr, k);
        end
      end
    end
  end

  always_comb begin
    w_gnt_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_gnt_idx == IDW'(i)) w_gnt_data = w_head[i*DW +: DW];
    end
  end

  // Output holding register; data/ID keep their last value when nothing is granted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_out_val  <= 1'b0;
      r_out_data <= '0;
      r_out_id   <= '0;
      r_rr_ptr   <= IDW'(NCH - 1);
    end else if (w_load) begin
      r_out_val <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_out_data <= w_gnt_data;
        r_out_id   <= w_gnt_idx;
        r_rr_ptr   <= w_gnt_idx;
      end
    end
  end

  assign bus.out_data_o = r_out_data;
  assign bus.out_id_o   = r_out_id;
  assign bus.out_val_o  = r_out_val;
endmodule

// File: tb/tb_mcdt_arb_n.sv
// Scoreboard bench for mcdt_arb_n (NCH=3, DW=32, DEPTH=32): per-channel data
// queues plus an optional expected-ID queue, popped as output beats are taken.
module tb_mcdt_arb_n;
  localparam int NCH   = 3;
  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int MW    = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mcdt_arb_n_if #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH)) bus ();
  mcdt_arb_n    #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  logic [DW-1:0] sb [NCH][$];
  int            exp_id [$];
  int            n_chk = 0;
  int            n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int sb_total();
    int s = 0;
    for (int i = 0; i < NCH; i++) s += sb[i].size();
    return s;
  endfunction

  // Record accepted writes and check every output beat taken at the coming edge.
  always @(negedge clk) begin
    int id;
    if (!rst) begin
      for (int i = 0; i < NCH; i++)
        if (bus.ch_valid_i[i] && bus.ch_ready_o[i]) sb[i].push_back(bus.ch_data_i[i*DW +: DW]);
      if (bus.out_val_o && bus.out_ready_i) begin
        id = int'(bus.out_id_o);
        check_val("id_range", (id < NCH), 1);
        if (id < NCH) begin
          check_val("beat_expected", (sb[id].size() != 0), 1);
          if (sb[id].size() != 0) check_val("beat_data", bus.out_data_o, sb[id].pop_front());
        end
        if (exp_id.size() != 0) check_val("arb_id", id, exp_id.pop_front());
      end
    end
  end

  task automatic preload(input int n0, input int n1, input int n2, input logic [31:0] base);
    int n [NCH];
    int mx;
    n[0] = n0; n[1] = n1; n[2] = n2;
    mx = n0;
    if (n1 > mx) mx = n1;
    if (n2 > mx) mx = n2;
    for (int c = 0; c < mx; c++) begin
      for (int i = 0; i < NCH; i++) begin
        bus.ch_valid_i[i] = (c < n[i]);
        bus.ch_data_i[i*DW +: DW] = base + 32'(i << 8) + 32'(c);
      end
      @(posedge clk); #1;
    end
    bus.ch_valid_i = '0;
  endtask

  task automatic drain(input string tag);
    int t = 0;
    bus.out_ready_i = 1'b1;
    while ((sb_total() != 0 || bus.out_val_o) && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    check_val(tag, (sb_total() == 0 && !bus.out_val_o), 1);
    check_val({tag, "_ids_left"}, exp_id.size(), 0);
  endtask

  initial begin
    int acc;
    logic r;
    bus.ch_data_i   = '0;
    bus.ch_valid_i  = '0;
    bus.ch_en_i     = '1;
    bus.arb_mode_i  = 1'b0;
    bus.out_ready_i = 1'b0;
    #12;
    check_val("rst_val", bus.out_val_o, 0);
    check_val("rst_data", bus.out_data_o, 0);
    check_val("rst_id", bus.out_id_o, 0);
    check_val("rst_ready", bus.ch_ready_o, 3'b111);
    for (int i = 0; i < NCH; i++) check_val("rst_margin", bus.ch_margin_o[i*MW +: MW], DEPTH);
    @(posedge clk); #1;
    rst = 1'b0;

    // Latency: one word on ch1 shows up one edge after acceptance
    bus.out_ready_i = 1'b1;
    bus.ch_data_i[1*DW +: DW] = 32'hA5A5_0001;
    bus.ch_valid_i[1] = 1'b1;
    check_val("lat_ready", bus.ch_ready_o[1], 1);
    @(posedge clk); #1;
    bus.ch_valid_i = '0;
    check_val("lat_e0_val", bus.out_val_o, 0);
    @(posedge clk); #1;
    check_val("lat_e1_val", bus.out_val_o, 1);
    check_val("lat_e1_id", bus.out_id_o, 1);
    check_val("lat_e1_data", bus.out_data_o, 32'hA5A5_0001);
    @(posedge clk); #1;
    check_val("lat_e2_val", bus.out_val_o, 0);

    // Full: 32 in FIFO plus one in the output register
    bus.out_ready_i = 1'b0;
    acc = 0;
    for (int c = 0; c < 40; c++) begin
      bus.ch_data_i[0 +: DW] = 32'h0B00_0000 + 32'(acc);
      bus.ch_valid_i[0] = 1'b1;
      r = bus.ch_ready_o[0];
      @(posedge clk); #1;
      if (r) acc++;
    end
    bus.ch_valid_i = '0;
    check_val("full_accepted", acc, 33);
    check_val("full_margin", bus.ch_margin_o[0 +: MW], 0);
    check_val("full_ready", bus.ch_ready_o[0], 0);
    bus.out_ready_i = 1'b1;
    repeat (33) begin @(posedge clk); #1; end
    check_val("full_drained", sb[0].size(), 0);
    check_val("full_val_after", bus.out_val_o, 0);
    check_val("full_margin_back", bus.ch_margin_o[0 +: MW], DEPTH);

    // Fixed priority
    bus.out_ready_i = 1'b0;
    bus.arb_mode_i  = 1'b0;
    for (int i = 0; i < 12; i++) exp_id.push_back(i / 4);
    preload(4, 4, 4, 32'h1000_0000);
    drain("fp_drain");

    // Round robin
    bus.out_ready_i = 1'b0;
    bus.arb_mode_i  = 1'b1;
    for (int i = 0; i < 12; i++) exp_id.push_back(i % 3);
    preload(4, 4, 4, 32'h1100_0000);
    drain("rr_drain");

    // Round robin with ch1 running dry early
    bus.out_ready_i = 1'b0;
    foreach (exp_id[i]) exp_id.delete(i);
    exp_id = '{0, 1, 2, 0, 2, 0, 2, 0, 2};
    preload(4, 1, 4, 32'h1200_0000);
    drain("rr_skip_drain");

    // Enable off with stored words, then a 5-cycle stall
    bus.out_ready_i = 1'b0;
    bus.arb_mode_i  = 1'b0;
    preload(0, 0, 3, 32'h2000_0000);
    bus.ch_en_i[2] = 1'b0;
    #1;
    check_val("en_ready", bus.ch_ready_o[2], 0);
    check_val("en_margin", bus.ch_margin_o[2*MW +: MW], DEPTH - 2);
    bus.ch_data_i[2*DW +: DW] = 32'hDEAD_BEEF;
    bus.ch_valid_i[2] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check_val("stall_val", bus.out_val_o, 1);
      check_val("stall_data", bus.out_data_o, 32'h2000_0200);
      check_val("stall_id", bus.out_id_o, 2);
    end
    bus.ch_valid_i = '0;
    drain("en_drain");
    check_val("en_margin_back", bus.ch_margin_o[2*MW +: MW], DEPTH);
    bus.ch_en_i = '1;

    // Reset mid-stream discards everything
    bus.out_ready_i = 1'b0;
    bus.arb_mode_i  = 1'b1;
    preload(3, 3, 0, 32'h3000_0000);
    #2;
    rst = 1'b1;
    for (int i = 0; i < NCH; i++) sb[i].delete();
    exp_id.delete();
    #1;
    check_val("mid_rst_val", bus.out_val_o, 0);
    for (int i = 0; i < NCH; i++) check_val("mid_rst_margin", bus.ch_margin_o[i*MW +: MW], DEPTH);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready_i = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    check_val("post_rst_idle", bus.out_val_o, 0);

    // Round-robin pointer restarts at channel 0 after reset
    bus.out_ready_i = 1'b0;
    exp_id = '{0, 1, 2};
    preload(1, 1, 1, 32'h4000_0000);
    drain("post_rst_rr");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
